lm32_dp_ram: RTL and testbench

- Generic simple dual-port RAM: one write port, one read port, single clock domain.
- Used as the backing store of the LM32 ITLB. Each word holds {valid, tag, physical page frame number}.
- Read address is registered; the read data is the array word at the registered address.
- Write and read are independent and may target any addresses in the same cycle.

---
 rtl/lm32_dp_ram.sv | 47 ++++
 tb/tb_lm32_dp_ram.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lm32_dp_ram.sv
// Simple dual-port RAM (one write, one read port) with registered read address; ITLB backing store.
// Optional macro LM32_DP_RAM_ZERO_INIT_EN zero-fills the array at time zero.
module lm32_dp_ram #(
   parameter int unsigned data_width    = 1,
   parameter int unsigned address_width = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [address_width-1:0] read_address,
   input  logic                     enable_read,
   input  logic [address_width-1:0] write_address,
   input  logic                     enable_write,
   input  logic                     write_enable,
   input  logic [data_width-1:0]    write_data,
   output logic [data_width-1:0]    read_data
);

   localparam int unsigned depth = 1 << address_width;

   logic [data_width-1:0]    mem [depth];
   logic [address_width-1:0] ra;

`ifdef LM32_DP_RAM_ZERO_INIT_EN
   // Power-up contents; reset never touches the array.
   initial begin
      for (int i = 0; i < int'(depth); i++) mem[i] = '0;
   end
`else
`endif

   // Write port; no reset term so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (enable_write && write_enable && rst_n_i)
         mem[write_address] <= write_data;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         ra <= '0;
      else if (enable_read)
         ra <= read_address;
   end

   // Reading through the registered address gives write-through on collisions.
   assign read_data = mem[ra];

endmodule

// File: tb/tb_lm32_dp_ram.sv
// Directed bench for lm32_dp_ram: vector table plus hand sequences for async reset.
module tb_lm32_dp_ram;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic [AW-1:0] read_address;
   logic          enable_read;
   logic [AW-1:0] write_address;
   logic          enable_write;
   logic          write_enable;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;

   int n_vec  = 0;
   int n_fail = 0;

   lm32_dp_ram #(.data_width(DW), .address_width(AW)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .read_address (read_address),
      .enable_read  (enable_read),
      .write_address(write_address),
      .enable_write (enable_write),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string         name;
      logic          ew;
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          re;
      logic [AW-1:0] raddr;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [DW-1:0] exp);
      n_vec++;
      if (read_data !== exp) begin
         n_fail++;
         $display("FAIL %s: read_data=%h expected=%h", name, read_data, exp);
      end
   endtask

   task automatic drive(input logic ew, input logic we, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] wdata, input logic re, input logic [AW-1:0] raddr);
      enable_write  = ew;
      write_enable  = we;
      write_address = waddr;
      write_data    = wdata;
      enable_read   = re;
      read_address  = raddr;
   endtask

   task automatic apply(input vec_t v);
      drive(v.ew, v.we, v.waddr, v.wdata, v.re, v.raddr);
      @(posedge clk_i);
      #2;
      check(v.name, v.exp);
   endtask

   function automatic vec_t mk(input string name, input logic ew, input logic we,
                               input int waddr, input int wdata, input logic re,
                               input int raddr, input int exp);
      vec_t v;
      v.name  = name;
      v.ew    = ew;
      v.we    = we;
      v.waddr = AW'(waddr);
      v.wdata = DW'(wdata);
      v.re    = re;
      v.raddr = AW'(raddr);
      v.exp   = DW'(exp);
      return v;
   endfunction

   initial begin
      rst_n_i = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      repeat (2) @(posedge clk_i);
      #2;
      rst_n_i = 1'b1;

`ifndef LM32_DP_RAM_ZERO_INIT_EN
      // Flush the array so the init checks are deterministic without zero-init.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, AW'(i), '0, 1'b0, '0);
         @(posedge clk_i);
         #2;
      end
`endif

      for (int i = 0; i < 16; i++) vecs.push_back(mk($sformatf("init_rd%0d", i), 0, 0, 0, 0, 1, i, 8'h00));
      vecs.push_back(mk("wr_a5_at3",     1, 1, 3, 8'hA5, 1, 15, 8'h00));
      vecs.push_back(mk("rd3_a5",        0, 0, 0, 8'h00, 1, 3,  8'hA5));
      vecs.push_back(mk("gate_we0",      1, 0, 3, 8'hFF, 1, 3,  8'hA5));
      vecs.push_back(mk("gate_ew0",      0, 1, 3, 8'hFF, 1, 3,  8'hA5));
      vecs.push_back(mk("hold_re0",      0, 0, 0, 8'h00, 0, 5,  8'hA5));
      vecs.push_back(mk("hold_wt_3c",    1, 1, 3, 8'h3C, 0, 5,  8'h3C));
      vecs.push_back(mk("indep_wr5_rd3", 1, 1, 5, 8'h5A, 1, 3,  8'h3C));
      vecs.push_back(mk("rd5_5a",        0, 0, 0, 8'h00, 1, 5,  8'h5A));
      vecs.push_back(mk("collide_77",    1, 1, 9, 8'h77, 1, 9,  8'h77));
      vecs.push_back(mk("wr0_11_hold9",  1, 1, 0, 8'h11, 0, 2,  8'h77));

      foreach (vecs[i]) apply(vecs[i]);

      // Async reset between edges: ra clears without a clock.
      #1;
      rst_n_i = 1'b0;
      #1;
      check("async_rst_rd0", 8'h11);

      // Across an edge in reset: write and read-capture are both blocked.
      drive(1'b1, 1'b1, '0, 8'hEE, 1'b1, AW'(9));
      @(posedge clk_i);
      #2;
      check("rst_blocks_wr_rd", 8'h11);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      apply(mk("post_rst_rd9", 0, 0, 0, 8'h00, 1, 9, 8'h77));
      apply(mk("post_rst_rd0", 0, 0, 0, 8'h00, 1, 0, 8'h11));
      apply(mk("post_rst_wt0", 1, 1, 0, 8'hC3, 0, 7, 8'hC3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
